// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with a one-entry skid buffer.
// The main register drives ID, and in_ready is registered so there is no combinational path back from out_ready.
module if_id_pipe_reg #(
  parameter int                 PC_W      = 16,
  parameter int                 INSTR_W   = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [1:0]         occupancy
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // Valid never waits on ready.
  // Accept and consume are both evaluated at that same edge.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic               accept, consume;
  logic               load_main_in, load_main_skid, load_skid;
  logic [PC_W-1:0]    main_pc, skid_pc;
  logic [INSTR_W-1:0] main_instr, skid_instr;

  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      // Squash everything held; an entry offered this cycle is dropped as well.
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt    = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && consume) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end else if (consume) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            state_nxt      = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= EMPTY;
      in_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != FULL);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_pc    <= '0;
      main_instr <= NOP_INSTR;
      skid_pc    <= '0;
      skid_instr <= NOP_INSTR;
    end else begin
      if (load_main_in) begin
        main_pc    <= in_pc;
        main_instr <= in_instr;
      end else if (load_main_skid) begin
        main_pc    <= skid_pc;
        main_instr <= skid_instr;
      end
      if (load_skid) begin
        skid_pc    <= in_pc;
        skid_instr <= in_instr;
      end
    end
  end

  // When nothing is held the PC keeps its last value, but the instruction reads as a NOP.
  assign out_pc    = main_pc;
  assign out_instr = out_valid ? main_instr : NOP_INSTR;
  assign occupancy = state;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Bench for if_id_pipe_reg: directed vector table on a 16-bit instance, hand sequences for reset,
// and a randomized 32-bit instance checked against a queue model.
module tb_if_id_pipe_reg;

  localparam logic [15:0] NOP16 = 16'h0000;
  localparam logic [31:0] NOP32 = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [15:0] a_in_pc, a_in_instr, a_out_pc, a_out_instr;
  logic [1:0]  a_occ;

  if_id_pipe_reg #(.PC_W(16), .INSTR_W(16), .NOP_INSTR(NOP16)) dut16 (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_pc(a_in_pc), .in_instr(a_in_instr),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_pc(a_out_pc), .out_instr(a_out_instr),
    .occupancy(a_occ)
  );

  // 32-bit instance
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_pc, b_in_instr, b_out_pc, b_out_instr;
  logic [1:0]  b_occ;

  if_id_pipe_reg #(.PC_W(32), .INSTR_W(32), .NOP_INSTR(NOP32)) dut32 (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pc(b_in_pc), .in_instr(b_in_instr),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc), .out_instr(b_out_instr),
    .occupancy(b_occ)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string tag, input logic ov, input logic [15:0] pc,
                       input logic [15:0] instr, input logic [1:0] occ, input logic rdy);
    n_vec++;
    chk({tag, " out_valid"}, {31'd0, a_out_valid}, {31'd0, ov});
    chk({tag, " out_pc"},    {16'd0, a_out_pc},    {16'd0, pc});
    chk({tag, " out_instr"}, {16'd0, a_out_instr}, {16'd0, instr});
    chk({tag, " occupancy"}, {30'd0, a_occ},       {30'd0, occ});
    chk({tag, " in_ready"},  {31'd0, a_in_ready},  {31'd0, rdy});
  endtask

  task automatic drive16(input logic fl, input logic iv, input logic [15:0] pc,
                         input logic [15:0] instr, input logic ordy);
    a_flush = fl; a_in_valid = iv; a_in_pc = pc; a_in_instr = instr; a_out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Directed vectors: inputs applied before an edge, expected outputs sampled after it.
  typedef struct {
    logic        fl;
    logic        iv;
    logic [15:0] pc;
    logic [15:0] instr;
    logic        ordy;
    logic        e_ov;
    logic [15:0] e_pc;
    logic [15:0] e_instr;
    logic [1:0]  e_occ;
    logic        e_rdy;
  } vec_t;

  function automatic vec_t mk(logic fl, logic iv, logic [15:0] pc, logic [15:0] instr, logic ordy,
                              logic e_ov, logic [15:0] e_pc, logic [15:0] e_instr,
                              logic [1:0] e_occ, logic e_rdy);
    vec_t v;
    v.fl = fl; v.iv = iv; v.pc = pc; v.instr = instr; v.ordy = ordy;
    v.e_ov = e_ov; v.e_pc = e_pc; v.e_instr = e_instr; v.e_occ = e_occ; v.e_rdy = e_rdy;
    return v;
  endfunction

  vec_t tbl[19];

  // Reference model for the randomized run: entries in flight, oldest first.
  logic [63:0] exp_q[$];
  logic        m_rdy;
  logic [31:0] m_last_pc;

  initial begin
    tbl[0]  = mk(0, 1, 16'h0010, 16'hA123, 1,  1, 16'h0010, 16'hA123, 2'd1, 1);
    tbl[1]  = mk(0, 0, 16'h0000, 16'h0000, 1,  0, 16'h0010, NOP16,    2'd0, 1);
    tbl[2]  = mk(0, 1, 16'h0000, 16'h1000, 1,  1, 16'h0000, 16'h1000, 2'd1, 1);
    tbl[3]  = mk(0, 1, 16'h0002, 16'h1002, 1,  1, 16'h0002, 16'h1002, 2'd1, 1);
    tbl[4]  = mk(0, 1, 16'h0004, 16'h1004, 1,  1, 16'h0004, 16'h1004, 2'd1, 1);
    tbl[5]  = mk(0, 0, 16'h0000, 16'h0000, 1,  0, 16'h0004, NOP16,    2'd0, 1);
    tbl[6]  = mk(0, 1, 16'h0100, 16'h2100, 0,  1, 16'h0100, 16'h2100, 2'd1, 1);
    tbl[7]  = mk(0, 1, 16'h0102, 16'h2102, 0,  1, 16'h0100, 16'h2100, 2'd2, 0);
    tbl[8]  = mk(0, 1, 16'h0104, 16'h2104, 0,  1, 16'h0100, 16'h2100, 2'd2, 0);
    tbl[9]  = mk(0, 1, 16'h0104, 16'h2104, 1,  1, 16'h0102, 16'h2102, 2'd1, 1);
    tbl[10] = mk(0, 0, 16'h0000, 16'h0000, 1,  0, 16'h0102, NOP16,    2'd0, 1);
    tbl[11] = mk(0, 1, 16'h0200, 16'h3200, 0,  1, 16'h0200, 16'h3200, 2'd1, 1);
    tbl[12] = mk(0, 1, 16'h0202, 16'h3202, 0,  1, 16'h0200, 16'h3200, 2'd2, 0);
    tbl[13] = mk(1, 0, 16'h0000, 16'h0000, 0,  0, 16'h0200, NOP16,    2'd0, 1);
    tbl[14] = mk(0, 1, 16'h0300, 16'h4300, 0,  1, 16'h0300, 16'h4300, 2'd1, 1);
    tbl[15] = mk(1, 1, 16'h0302, 16'h4302, 1,  0, 16'h0300, NOP16,    2'd0, 1);
    tbl[16] = mk(0, 0, 16'h0000, 16'h0000, 0,  0, 16'h0300, NOP16,    2'd0, 1);
    tbl[17] = mk(1, 1, 16'h0400, 16'h5400, 0,  0, 16'h0300, NOP16,    2'd0, 1);
    tbl[18] = mk(0, 1, 16'h0500, 16'h5500, 1,  1, 16'h0500, 16'h5500, 2'd1, 1);

    drive16(0, 0, 16'h0, 16'h0, 0);
    b_flush = 0; b_in_valid = 0; b_in_pc = '0; b_in_instr = '0; b_out_ready = 0;

    // Reset held across several edges: no entry may be accepted and in_ready stays low.
    a_in_valid = 1; a_in_pc = 16'hDEAD; a_in_instr = 16'hBEEF;
    step();
    step();
    chk16("reset", 0, 16'h0000, NOP16, 2'd0, 0);
    a_in_valid = 0;
    #3 rst = 1'b1;
    step();
    chk16("reset release", 0, 16'h0000, NOP16, 2'd0, 1);

    for (int i = 0; i < 19; i++) begin
      drive16(tbl[i].fl, tbl[i].iv, tbl[i].pc, tbl[i].instr, tbl[i].ordy);
      step();
      chk16($sformatf("vec%0d", i), tbl[i].e_ov, tbl[i].e_pc, tbl[i].e_instr, tbl[i].e_occ, tbl[i].e_rdy);
    end

    // Fill to FULL, then pulse reset between edges.
    drive16(0, 0, 16'h0, 16'h0, 1);
    step();
    drive16(0, 1, 16'h0700, 16'h7700, 0);
    step();
    drive16(0, 1, 16'h0702, 16'h7702, 0);
    step();
    chk16("pre-reset full", 1, 16'h0700, 16'h7700, 2'd2, 0);
    #3 rst = 1'b0;
    #1;
    chk16("async reset", 0, 16'h0000, NOP16, 2'd0, 0);
    step();
    chk16("reset held", 0, 16'h0000, NOP16, 2'd0, 0);
    #3 rst = 1'b1;
    step();
    chk16("mid reset release", 0, 16'h0000, NOP16, 2'd0, 1);
    drive16(0, 1, 16'h0600, 16'h6600, 0);
    step();
    chk16("post-reset first", 1, 16'h0600, 16'h6600, 2'd1, 1);
    drive16(0, 1, 16'h0602, 16'h6602, 0);
    step();
    chk16("post-reset second", 1, 16'h0600, 16'h6600, 2'd2, 0);
    drive16(0, 0, 16'h0, 16'h0, 1);
    step();
    chk16("post-reset drain", 1, 16'h0602, 16'h6602, 2'd1, 1);

    // Randomized run on the 32-bit instance after a fresh reset.
    drive16(0, 0, 16'h0, 16'h0, 0);
    #3 rst = 1'b0;
    step();
    #3 rst = 1'b1;
    step();
    m_rdy = 1'b1;
    m_last_pc = '0;
    exp_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic acc, cons;
      bit drain;
      drain = (cyc >= 2980);
      b_in_valid  = drain ? 1'b0 : ($urandom_range(0, 3) != 0);
      b_out_ready = drain ? 1'b1 : ($urandom_range(0, 2) != 0);
      b_flush     = drain ? 1'b0 : ($urandom_range(0, 24) == 0);
      b_in_pc     = $urandom;
      b_in_instr  = $urandom;
      acc  = b_in_valid & m_rdy;
      cons = (exp_q.size() != 0) & b_out_ready;
      if (b_flush) begin
        exp_q.delete();
      end else begin
        if (cons) void'(exp_q.pop_front());
        if (acc) exp_q.push_back({b_in_pc, b_in_instr});
      end
      m_rdy = (exp_q.size() < 2);
      if (exp_q.size() != 0) m_last_pc = exp_q[0][63:32];
      step();
      n_vec++;
      chk("rnd out_valid", {31'd0, b_out_valid}, {31'd0, exp_q.size() != 0});
      chk("rnd out_pc", b_out_pc, m_last_pc);
      chk("rnd out_instr", b_out_instr, (exp_q.size() != 0) ? exp_q[0][31:0] : NOP32);
      chk("rnd occupancy", {30'd0, b_occ}, exp_q.size());
      chk("rnd in_ready", {31'd0, b_in_ready}, {31'd0, m_rdy});
    end
    chk("rnd drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_id_pipe_reg.md
IF_ID_PIPE_REG -- requirements
Module: if_id_pipe_reg

Interface
REQ-001 Parameter PC_W, default 16: width of the program-counter field.
REQ-002 Parameter INSTR_W, default 16: width of the instruction field.
REQ-003 Parameter NOP_INSTR, default 16'h0000 (INSTR_W bits): instruction word presented when no valid entry is held.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous squash of all held entries (branch taken / exception).
REQ-007 in_valid  input  1  IF stage presents an entry.
REQ-008 in_ready  output  1  stage can accept an entry this cycle.
REQ-009 in_pc  input  PC_W  PC of the presented entry.
REQ-010 in_instr  input  INSTR_W  instruction of the presented entry.
REQ-011 out_valid  output  1  ID stage is offered a valid entry.
REQ-012 out_ready  input  1  ID stage consumes the offered entry; low = stall.
REQ-013 out_pc  output  PC_W  PC of the offered entry.
REQ-014 out_instr  output  INSTR_W  instruction of the offered entry.
REQ-015 occupancy  output  2  number of held entries, 0..2.

Function
REQ-016 Storage is two entries: main register (drives outputs) and skid register; states EMPTY (0), ONE (1) and FULL (2), encoded directly by occupancy.
REQ-017 Accept = in_valid & in_ready; consume = out_valid & out_ready; both are evaluated on the same rising edge.
REQ-018 in_ready is a registered signal equal to (state != FULL) and carries no combinational path from out_ready.
REQ-019 out_valid = (state != EMPTY); out_pc/out_instr come from the main register; when out_valid = 0, out_instr = NOP_INSTR and out_pc holds its last value.
REQ-020 EMPTY: accept -> ONE, entry loaded into main (zero-cycle bubble; visible on outputs the following cycle).
REQ-021 ONE: accept & consume -> ONE, main loaded with new entry; accept only -> FULL, new entry loaded into skid; consume only -> EMPTY; neither -> ONE, hold.
REQ-022 FULL: consume -> ONE, skid moves to main; no consume -> FULL, hold; accept is impossible because in_ready = 0.
REQ-023 Entries are delivered strictly in acceptance order, with no duplication and no loss absent flush.
REQ-024 flush = 1 at an edge: next state is EMPTY regardless of accept/consume in that cycle; an entry accepted in the flush cycle is discarded; in_ready = 1 the following cycle.
REQ-025 A consume in the flush cycle is a legal handshake; ID owns the consumed entry.
REQ-026 The skid register's contents are don't-care when not occupied; the main register's PC is not cleared by flush.
REQ-027 All widths are set by parameters only; no hard-coded 16-bit assumption is permitted.

Reset
REQ-028 rst low asynchronously forces state EMPTY, occupancy 0, out_valid 0, out_pc 0, out_instr NOP_INSTR, and in_ready 0.
REQ-029 in_ready rises to 1 on the first rising clk edge after rst deasserts; no entry is accepted while rst is low.
REQ-030 Reset asserted mid-transfer discards all held entries, with no partial update.

Verification
REQ-031 Reset release, then in_valid=1, pc=0x0010, instr=0xA123, out_ready=1 -> next cycle out_valid=1, out_pc=0x0010, out_instr=0xA123, occupancy=1.
REQ-032 Streaming pc 0x0000,0x0002,0x0004 with out_ready=1 -> one entry consumed per cycle in order, occupancy stays 1, in_ready stays 1.
REQ-033 out_ready=0 while two entries arrive -> occupancy=2, in_ready=0, out_pc holds first PC; out_ready=1 -> second PC appears the next cycle, in_ready=1.
REQ-034 FULL state plus flush=1 -> next cycle occupancy=0, out_valid=0, out_instr=NOP_INSTR, in_ready=1; the flushed PCs never appear.
REQ-035 rst pulsed low mid-stream, between edges -> outputs immediately at reset values; after release the first accepted entry is the first one output.
REQ-036 Randomised in_valid/out_ready/flush, with PC_W=32 and INSTR_W=32 -> scoreboard confirms in-order, lossless delivery of every non-flushed entry.
